// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: CPU op codes,
// memory byteExt/wEn codes, controller states and small op classifiers.
package dm_pkg;

  typedef enum logic [2:0] {
    OP_LBU = 3'b000,
    OP_LB  = 3'b001,
    OP_LW  = 3'b010,
    OP_LHU = 3'b011,
    OP_LH  = 3'b100,
    OP_SB  = 3'b101,
    OP_SW  = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    BX_BYTE_ZEXT  = 2'b00,
    BX_BYTE_SEXT  = 2'b01,
    BX_STORE_BYTE = 2'b10,
    BX_WORD       = 2'b11
  } byte_ext_e;

  typedef enum logic [1:0] {
    WEN_NONE  = 2'b00,
    WEN_WRITE = 2'b01
  } wen_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  function automatic logic is_store(op_e op);
    return op inside {OP_SB, OP_SW, OP_SH};
  endfunction

  function automatic logic is_half(op_e op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic is_word(op_e op);
    return op inside {OP_LW, OP_SW};
  endfunction

  function automatic logic misaligned(op_e op, logic [1:0] lo2);
    if (is_word(op)) return lo2 != 2'b00;
    if (is_half(op)) return lo2[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_load_ext.sv
// Load result extension: turns the raw captured memory data into the
// architectural load result for each op; stores yield zero.
module load_ext
  import dm_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (op)
      OP_LBU:  data = {24'b0, raw[7:0]};
      OP_LB:   data = {{24{raw[7]}}, raw[7:0]};
      OP_LW:   data = raw;
      OP_LHU:  data = {16'b0, raw[15:0]};
      OP_LH:   data = {{16{raw[15]}}, raw[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: sequences byte/half/word loads and stores
// onto a byte/word big-endian memory port, with misalignment detection.
module dm_access_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [1:0]        mem_byteExt,
  output logic [1:0]        mem_wEn,
  input  logic [31:0]       mem_dout
);
  import dm_pkg::*;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        hi_q, hi_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       ext_raw, ext_data;
  op_e               op_in;

  assign op_in = op_e'(req_op);

  // Halfword loads are assembled from two byte reads, high byte first.
  assign ext_raw = (state_q == ST_ACC1) ? {16'b0, hi_q, mem_dout[7:0]} : mem_dout;

  load_ext u_load_ext (
    .op   (op_q),
    .raw  (ext_raw),
    .data (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LBU;
      addr_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = misaligned(op_in, req_addr[1:0]) ? ST_RESP : ST_ACC0;
      ST_ACC0: state_d = is_half(op_q) ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        op_d    = op_in;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = misaligned(op_in, req_addr[1:0]);
      end
      ST_ACC0: begin
        if (is_half(op_q)) hi_d = mem_dout[7:0];
        else               rdata_d = ext_data;
      end
      ST_ACC1: rdata_d = ext_data;
      ST_RESP: if (resp_ready) begin
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    resp_valid  = (state_q == ST_RESP);
    resp_rdata  = rdata_q;
    resp_err    = err_q;
    mem_addr    = '0;
    mem_din     = '0;
    mem_byteExt = BX_WORD;
    mem_wEn     = WEN_NONE;
    case (state_q)
      ST_ACC0: begin
        mem_addr = addr_q;
        mem_wEn  = is_store(op_q) ? WEN_WRITE : WEN_NONE;
        // Byte loads always read zero-extended; load_ext applies the sign.
        if (is_word(op_q))       mem_byteExt = BX_WORD;
        else if (is_store(op_q)) mem_byteExt = BX_STORE_BYTE;
        else                     mem_byteExt = BX_BYTE_ZEXT;
        if (op_q == OP_SH)       mem_din = {24'b0, wdata_q[15:8]};
        else if (is_store(op_q)) mem_din = wdata_q;
      end
      ST_ACC1: begin
        mem_addr    = addr_q + ADDR_W'(1);
        mem_wEn     = is_store(op_q) ? WEN_WRITE : WEN_NONE;
        mem_byteExt = is_store(op_q) ? BX_STORE_BYTE : BX_BYTE_ZEXT;
        if (is_store(op_q)) mem_din = {24'b0, wdata_q[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: big-endian byte memory behind the
// port, directed scenarios plus random traffic against a byte-array model.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_byteExt;
  logic [1:0]  mem_wEn;
  logic [31:0] mem_dout;

  logic [7:0]  mem [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        mem_clr = 1'b0;
  int          wr_count = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_byteExt(mem_byteExt),
    .mem_wEn(mem_wEn), .mem_dout(mem_dout)
  );

  // Memory environment: combinational read, write on rising edge.
  always_comb begin
    mem_dout = '0;
    case (mem_byteExt)
      2'b11:   mem_dout = {mem[mem_addr], mem[12'(mem_addr + 12'd1)],
                           mem[12'(mem_addr + 12'd2)], mem[12'(mem_addr + 12'd3)]};
      2'b01:   mem_dout = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
      default: mem_dout = {24'b0, mem[mem_addr]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_wEn == 2'b01) begin
      wr_count <= wr_count + 1;
      if (mem_byteExt == 2'b11) begin
        mem[mem_addr]               <= mem_din[31:24];
        mem[12'(mem_addr + 12'd1)] <= mem_din[23:16];
        mem[12'(mem_addr + 12'd2)] <= mem_din[15:8];
        mem[12'(mem_addr + 12'd3)] <= mem_din[7:0];
      end else begin
        mem[mem_addr] <= mem_din[7:0];
      end
    end
  end

  // Reference: executes one op on ref_mem; returns result, error flag,
  // accept-to-response latency and number of memory write cycles.
  task automatic ref_exec(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] r, output logic e, output int lat, output int wr);
    int size, v;
    logic [11:0] a1, a2, a3;
    size = (op == 3'd2 || op == 3'd6) ? 4 : (op == 3'd3 || op == 3'd4 || op == 3'd7) ? 2 : 1;
    a1 = a + 12'd1; a2 = a + 12'd2; a3 = a + 12'd3;
    r = 0; wr = 0;
    e = (int'(a) % size) != 0;
    if (e) begin
      lat = 1;
      return;
    end
    lat = (size == 2) ? 3 : 2;
    case (op)
      3'd0: r = 32'(ref_mem[a]);
      3'd1: begin v = ref_mem[a]; if (v > 127) v -= 256; r = 32'(v); end
      3'd2: r = {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
      3'd3: r = 32'(ref_mem[a]) * 256 + 32'(ref_mem[a1]);
      3'd4: begin v = ref_mem[a] * 256 + ref_mem[a1]; if (v > 32767) v -= 65536; r = 32'(v); end
      3'd5: begin ref_mem[a] = wd[7:0]; wr = 1; end
      3'd6: begin
        ref_mem[a] = wd[31:24]; ref_mem[a1] = wd[23:16];
        ref_mem[a2] = wd[15:8]; ref_mem[a3] = wd[7:0]; wr = 1;
      end
      default: begin ref_mem[a] = wd[15:8]; ref_mem[a1] = wd[7:0]; wr = 2; end
    endcase
  endtask

  // Drives one transaction; while busy optionally holds junk store requests
  // on the request port, which must be ignored.
  task automatic do_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input int hold, input bit junk,
                        output logic [31:0] rd, output logic e, output int lat,
                        output int wr, output bit stable);
    int w0, n;
    logic [11:0] ja;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    w0 = wr_count;
    @(posedge clk); #1;
    ja = 12'($urandom) & 12'hFFC;
    req_valid = junk; req_op = 3'b110; req_addr = ja; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; e = resp_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (resp_rdata !== rd || resp_err !== e || resp_valid !== 1'b1 || req_ready !== 1'b0)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) stable = 1'b0;
    wr = wr_count - w0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", resp_err); end
    tests++; if (mem_wEn !== 2'b00) begin fails++; $display("FAIL reset_wen got %b want 00", mem_wEn); end
    tests++; if (mem_byteExt !== 2'b11 || mem_addr !== 12'h0 || mem_din !== 32'h0) begin
      fails++; $display("FAIL reset_mem_idle got ext=%b addr=%h din=%h want 11/0/0", mem_byteExt, mem_addr, mem_din);
    end
    mem_clr = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd, er; logic e, ee; int lat, el, wr, ew; bit st;
    ref_exec(3'd6, 12'h010, 32'h11223344, er, ee, el, ew);
    do_req(3'd6, 12'h010, 32'h11223344, 0, 0, rd, e, lat, wr, st);
    tests++; if (wr !== 1 || rd !== 32'h0 || lat !== 2) begin fails++; $display("FAIL sw got wr=%0d rd=%h lat=%0d want 1/0/2", wr, rd, lat); end
    ref_exec(3'd2, 12'h010, 32'h0, er, ee, el, ew);
    do_req(3'd2, 12'h010, 32'h0, 1, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'h11223344) begin fails++; $display("FAIL lw_data got %h want 11223344", rd); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL lw_err got %b want 0", e); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got %0d want 2", lat); end
  endtask

  task automatic test_byte();
    logic [31:0] rd, er; logic e, ee; int lat, el, wr, ew; bit st;
    ref_exec(3'd1, 12'h013, 32'h0, er, ee, el, ew);
    do_req(3'd1, 12'h013, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'h00000044 || lat !== 2) begin fails++; $display("FAIL lb_013 got %h lat=%0d want 00000044 lat=2", rd, lat); end
    ref_exec(3'd6, 12'h010, 32'h80FF0000, er, ee, el, ew);
    do_req(3'd6, 12'h010, 32'h80FF0000, 0, 0, rd, e, lat, wr, st);
    ref_exec(3'd1, 12'h010, 32'h0, er, ee, el, ew);
    do_req(3'd1, 12'h010, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sign got %h want FFFFFF80", rd); end
    ref_exec(3'd0, 12'h010, 32'h0, er, ee, el, ew);
    do_req(3'd0, 12'h010, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu_zero got %h want 00000080", rd); end
    ref_exec(3'd5, 12'h011, 32'h123456A7, er, ee, el, ew);
    do_req(3'd5, 12'h011, 32'h123456A7, 0, 0, rd, e, lat, wr, st);
    ref_exec(3'd2, 12'h010, 32'h0, er, ee, el, ew);
    do_req(3'd2, 12'h010, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'h80A70000) begin fails++; $display("FAIL sb_merge got %h want 80A70000", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd, er; logic e, ee; int lat, el, wr, ew; bit st;
    ref_exec(3'd6, 12'h020, 32'h0, er, ee, el, ew);
    do_req(3'd6, 12'h020, 32'h0, 0, 0, rd, e, lat, wr, st);
    ref_exec(3'd7, 12'h022, 32'h0000BEEF, er, ee, el, ew);
    do_req(3'd7, 12'h022, 32'h0000BEEF, 0, 0, rd, e, lat, wr, st);
    tests++; if (wr !== 2 || lat !== 3) begin fails++; $display("FAIL sh got writes=%0d lat=%0d want 2/3", wr, lat); end
    ref_exec(3'd2, 12'h020, 32'h0, er, ee, el, ew);
    do_req(3'd2, 12'h020, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL sh_word got %h want 0000BEEF", rd); end
    ref_exec(3'd4, 12'h022, 32'h0, er, ee, el, ew);
    do_req(3'd4, 12'h022, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'hFFFFBEEF || lat !== 3) begin fails++; $display("FAIL lh got %h lat=%0d want FFFFBEEF lat=3", rd, lat); end
    ref_exec(3'd3, 12'h022, 32'h0, er, ee, el, ew);
    do_req(3'd3, 12'h022, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'h0000BEEF || lat !== 3) begin fails++; $display("FAIL lhu got %h lat=%0d want 0000BEEF lat=3", rd, lat); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic e; int lat, wr; bit st;
    do_req(3'd2, 12'h012, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr !== 0) begin
      fails++; $display("FAIL lw_misalign got err=%b rd=%h lat=%0d wr=%0d want 1/0/1/0", e, rd, lat, wr);
    end
    do_req(3'd7, 12'h021, 32'hFFFFFFFF, 0, 0, rd, e, lat, wr, st);
    tests++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr !== 0) begin
      fails++; $display("FAIL sh_misalign got err=%b rd=%h lat=%0d wr=%0d want 1/0/1/0", e, rd, lat, wr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, er; logic e, ee; int lat, el, wr, ew; bit st;
    ref_exec(3'd2, 12'h010, 32'h0, er, ee, el, ew);
    do_req(3'd2, 12'h010, 32'h0, 5, 1, rd, e, lat, wr, st);
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL hold_stable got %b want 1", st); end
    tests++; if (rd !== er || wr !== 0) begin fails++; $display("FAIL hold_data got %h wr=%0d want %h wr=0", rd, wr, er); end
  endtask

  task automatic test_reset_mid_sh();
    logic [31:0] rd, er; logic e, ee; int lat, el, wr, ew, w0; bit st;
    ref_exec(3'd6, 12'h030, 32'h0, er, ee, el, ew);
    do_req(3'd6, 12'h030, 32'h0, 0, 0, rd, e, lat, wr, st);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; req_addr = 12'h030; req_wdata = 32'h0000A5C3;
    w0 = wr_count;
    @(posedge clk); #1 req_valid = 1'b0;
    tests++; if (mem_wEn !== 2'b01 || mem_addr !== 12'h030 || mem_din !== 32'hA5) begin
      fails++; $display("FAIL sh_acc0 got wen=%b addr=%h din=%h want 01/030/A5", mem_wEn, mem_addr, mem_din);
    end
    @(posedge clk); #1;
    tests++; if (mem_wEn !== 2'b01 || mem_addr !== 12'h031 || mem_din !== 32'hC3) begin
      fails++; $display("FAIL sh_acc1 got wen=%b addr=%h din=%h want 01/031/C3", mem_wEn, mem_addr, mem_din);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (mem_wEn !== 2'b00 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL rst_mid got wen=%b rdy=%b vld=%b want 00/1/0", mem_wEn, req_ready, resp_valid);
    end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    tests++; if (wr_count - w0 !== 1) begin fails++; $display("FAIL rst_writes got %0d want 1", wr_count - w0); end
    ref_mem[12'h030] = 8'hA5;
    do_req(3'd2, 12'h030, 32'h0, 0, 0, rd, e, lat, wr, st);
    tests++; if (rd !== 32'hA5000000) begin fails++; $display("FAIL rst_hi_only got %h want A5000000", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, er, wd; logic e, ee; int lat, el, wr, ew, hold; bit st, junk;
    logic [2:0] op; logic [11:0] a;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a = 12'h100 + 12'($urandom_range(0, 15));
      wd = $urandom;
      hold = $urandom_range(0, 3);
      junk = 1'($urandom_range(0, 1));
      ref_exec(op, a, wd, er, ee, el, ew);
      do_req(op, a, wd, hold, junk, rd, e, lat, wr, st);
      tests++; if (rd !== er) begin fails++; $display("FAIL rnd_rdata op=%0d a=%h got %h want %h", op, a, rd, er); end
      tests++; if (e !== ee) begin fails++; $display("FAIL rnd_err op=%0d a=%h got %b want %b", op, a, e, ee); end
      tests++; if (lat !== el) begin fails++; $display("FAIL rnd_lat op=%0d a=%h got %0d want %0d", op, a, lat, el); end
      tests++; if (wr !== ew) begin fails++; $display("FAIL rnd_writes op=%0d a=%h got %0d want %0d", op, a, wr, ew); end
      tests++; if (st !== 1'b1) begin fails++; $display("FAIL rnd_stable op=%0d a=%h got %b want 1", op, a, st); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_backpressure();
    test_reset_mid_sh();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width toward data memory.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  CPU request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_op  input  3  000 LBU, 001 LB, 010 LW, 011 LHU, 100 LH, 101 SB, 110 SW, 111 SH.
REQ-007 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-justified for SB/SH.
REQ-009 SHALL have port resp_valid  output  1  response held until resp_ready.
REQ-010 SHALL have port resp_ready  input  1  CPU accepts response.
REQ-011 SHALL have port resp_rdata  output  32  load result, 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  misaligned access flag.
REQ-013 SHALL have ports mem_addr ADDR_W, mem_din 32, mem_byteExt 2, mem_wEn 2 (outputs) and mem_dout 32 (input), driving the 4K data memory: byteExt 00 byte zero-ext, 01 byte sign-ext, 10 store byte, 11 word; wEn 01 write.

Function
REQ-014 SHALL implement states IDLE, ACC0, ACC1, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL on accept in IDLE register op/addr/wdata, go ACC0; if misaligned (LW/SW addr[1:0]!=0, LH/LHU/SH addr[0]!=0) go RESP directly with resp_err=1, no memory access.
REQ-016 SHALL in ACC0 drive mem_addr=addr; byte ops use byteExt 00/10, word ops 11, halfword ops byte access of the high byte (big-endian: byte at addr is MSB).
REQ-017 SHALL assert mem_wEn=01 only in ACC0/ACC1 of store ops; mem_wEn=00, mem_addr=0, mem_din=0, mem_byteExt=11 in all other states.
REQ-018 SHALL capture mem_dout at end of ACC0 (and ACC1) for loads; byte loads take dout as returned, word loads take full word.
REQ-019 SHALL for LH/LHU go ACC0->ACC1, ACC1 accessing addr+1 (low byte, byteExt 00), result {hi,lo} zero-extended (LHU) or sign-extended from bit 15 (LH).
REQ-020 SHALL for SH write req_wdata[15:8] to addr in ACC0 and req_wdata[7:0] to addr+1 in ACC1, mem_din = {24'b0, byte}.
REQ-021 SHALL for SB/SW drive mem_din = req_wdata and go ACC0->RESP.
REQ-022 SHALL latency accept-to-resp_valid: 2 cycles byte/word, 3 cycles halfword, 1 cycle error.
REQ-023 SHALL in RESP hold resp_valid, resp_rdata, resp_err stable until resp_ready=1, then go IDLE next edge; no new accept in that same cycle.
REQ-024 SHALL ignore req_valid outside IDLE; request inputs need only be valid in the accept cycle.

Reset
REQ-025 SHALL on rst_n=0 immediately force state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_wEn=00.
REQ-026 SHALL, if reset asserts during ACC0/ACC1, perform no further memory write; a partially written SH is not rolled back.

Structure
REQ-027 SHALL take op encodings, byteExt/wEn encodings and state enum from shared package dm_pkg.
REQ-028 SHALL place result extension (byte/half/word, sign/zero) in combinational sub-module load_ext.

Verification
REQ-029 SHALL test SW addr 0x010 data 0x11223344, then LW 0x010 -> resp_rdata 0x11223344, err 0, latency 2.
REQ-030 SHALL test after REQ-029 LB 0x013 -> 0x00000044; LB 0x010 with word 0x80FF0000 -> 0xFFFFFF80, LBU -> 0x00000080.
REQ-031 SHALL test SH addr 0x022 data 0x0000BEEF over word 0 -> word 0x0000BEEF, LH 0x022 -> 0xFFFFBEEF, LHU -> 0x0000BEEF, latency 3.
REQ-032 SHALL test LW 0x012 and SH 0x021 -> resp_err 1, rdata 0, mem_wEn never 01, latency 1.
REQ-033 SHALL test resp_ready held low 5 cycles -> resp outputs stable, req_ready 0 throughout.
REQ-034 SHALL test rst_n pulsed low in SH ACC1 -> mem_wEn drops to 00 same cycle, state IDLE, high byte written only.
